// File: rtl/pwm_capture.sv
// PWM capture receiver: measures low time and period of an active-low PWM
// input between falling edges, with stuck-input detection.
module pwm_capture #(
    parameter int pwm_bits = 12
) (
    input  logic                clk_pwm,
    input  logic                rst,
    input  logic                pwm_in,
    output logic [pwm_bits-1:0] duty_out,
    output logic [pwm_bits:0]   period_out,
    output logic                valid,
    output logic                stuck
);

    localparam int CW = pwm_bits + 1;
    localparam logic [CW-1:0]       CTR_MAX  = '1;
    localparam logic [CW-1:0]       CTR_ONE  = CW'(1);
    localparam logic [pwm_bits-1:0] DUTY_MAX = '1;

    typedef enum logic [1:0] {ARM, MEAS, STUCK} state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CTR_MAX) ? v : v + CTR_ONE;
    endfunction

    function automatic logic [pwm_bits-1:0] sat_duty(input logic [CW-1:0] v);
        return (v > {1'b0, DUTY_MAX}) ? DUTY_MAX : v[pwm_bits-1:0];
    endfunction

    state_t              state, state_n;
    logic                s1, s2, s3;
    logic                fall;
    logic [CW-1:0]       per_ctr, per_n;
    logic [CW-1:0]       low_ctr, low_n;
    logic [pwm_bits-1:0] duty_n;
    logic [pwm_bits:0]   period_n;
    logic                valid_n, stuck_n;

    assign fall = s3 & ~s2;

    // Input synchronizer plus edge-detect delay; idle level is high (off)
    always_ff @(posedge clk_pwm or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk_pwm or posedge rst) begin
        if (rst) begin
            state      <= ARM;
            per_ctr    <= '0;
            low_ctr    <= '0;
            duty_out   <= '0;
            period_out <= '0;
            valid      <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            state      <= state_n;
            per_ctr    <= per_n;
            low_ctr    <= low_n;
            duty_out   <= duty_n;
            period_out <= period_n;
            valid      <= valid_n;
            stuck      <= stuck_n;
        end
    end

    always_comb begin
        state_n  = state;
        per_n    = per_ctr;
        low_n    = low_ctr;
        duty_n   = duty_out;
        period_n = period_out;
        valid_n  = 1'b0;
        stuck_n  = stuck;
        case (state)
            ARM: begin
                if (fall) begin
                    per_n   = CTR_ONE;
                    low_n   = CTR_ONE;
                    state_n = MEAS;
                end else if (per_ctr == CTR_MAX) begin
                    state_n  = STUCK;
                    stuck_n  = 1'b1;
                    valid_n  = 1'b1;
                    period_n = '0;
                    duty_n   = s2 ? '0 : DUTY_MAX;
                end else begin
                    per_n = sat_inc(per_ctr);
                end
            end
            MEAS: begin
                // A falling edge takes priority over the timeout in the same cycle
                if (fall) begin
                    period_n = per_ctr;
                    duty_n   = sat_duty(low_ctr);
                    valid_n  = 1'b1;
                    per_n    = CTR_ONE;
                    low_n    = CTR_ONE;
                end else if (per_ctr == CTR_MAX) begin
                    state_n  = STUCK;
                    stuck_n  = 1'b1;
                    valid_n  = 1'b1;
                    period_n = '0;
                    duty_n   = s2 ? '0 : DUTY_MAX;
                end else begin
                    per_n = sat_inc(per_ctr);
                    if (!s2) low_n = sat_inc(low_ctr);
                end
            end
            STUCK: begin
                // Recovery edge opens a fresh period, so it reports nothing
                if (fall) begin
                    stuck_n = 1'b0;
                    per_n   = CTR_ONE;
                    low_n   = CTR_ONE;
                    state_n = MEAS;
                end
            end
            default: state_n = ARM;
        endcase
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture at pwm_bits=4 (period 16, timeout 31).
module tb_pwm_capture;

    logic       clk_pwm = 1'b0;
    logic       rst;
    logic       pwm_in;
    logic [3:0] duty_out;
    logic [4:0] period_out;
    logic       valid;
    logic       stuck;

    pwm_capture #(.pwm_bits(4)) dut (
        .clk_pwm    (clk_pwm),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .period_out (period_out),
        .valid      (valid),
        .stuck      (stuck)
    );

    always #5 clk_pwm = ~clk_pwm;

    typedef struct {
        int low;
        int high;
        int exp_duty;
        int exp_period;
    } vec_t;

    typedef struct {
        int duty;
        int period;
        int stk;
    } strobe_t;

    vec_t    vecs[4];
    strobe_t sq[$];
    int      n_cmp = 0;
    int      n_err = 0;
    logic    prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_strobe(input string name, input int idx, input int d,
                                input int p, input int s);
        if (idx < 0 || idx >= sq.size()) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: strobe %0d missing (have %0d)", name, idx, sq.size());
        end else begin
            check({name, ".duty"}, sq[idx].duty, d);
            check({name, ".period"}, sq[idx].period, p);
            check({name, ".stuck"}, sq[idx].stk, s);
        end
    endtask

    // Record every strobe and flag back-to-back valid
    always @(negedge clk_pwm) begin
        if (valid) begin
            check("valid_not_consecutive", int'(prev_valid), 0);
            sq.push_back('{int'(duty_out), int'(period_out), int'(stuck)});
        end
        prev_valid = valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_pwm);
        #1;
    endtask

    task automatic drive_period(input int low, input int high);
        pwm_in = 1'b0;
        tick(low);
        pwm_in = 1'b1;
        tick(high);
    endtask

    initial begin
        vecs[0] = '{5, 11, 5, 16};
        vecs[1] = '{1, 15, 1, 16};
        vecs[2] = '{8, 8, 8, 16};
        vecs[3] = '{15, 1, 15, 16};

        rst    = 1'b1;
        pwm_in = 1'b1;
        tick(3);
        check("reset.duty", int'(duty_out), 0);
        check("reset.period", int'(period_out), 0);
        check("reset.valid", int'(valid), 0);
        check("reset.stuck", int'(stuck), 0);
        rst = 1'b0;
        tick(3);

        // Compare sweep; first entry after reset loses its first edge to arming
        for (int i = 0; i < 4; i++) begin
            sq.delete();
            repeat (3) drive_period(vecs[i].low, vecs[i].high);
            check($sformatf("sweep%0d.count", i), sq.size(), (i == 0) ? 2 : 3);
            check_strobe($sformatf("sweep%0d.a", i), sq.size() - 2,
                         vecs[i].exp_duty, vecs[i].exp_period, 0);
            check_strobe($sformatf("sweep%0d.b", i), sq.size() - 1,
                         vecs[i].exp_duty, vecs[i].exp_period, 0);
        end

        // Stuck off from reset
        rst = 1'b1;
        tick(2);
        pwm_in = 1'b1;
        rst = 1'b0;
        sq.delete();
        tick(28);
        check("stuck_off.early", int'(stuck), 0);
        tick(12);
        check("stuck_off.stuck", int'(stuck), 1);
        check("stuck_off.count", sq.size(), 1);
        check_strobe("stuck_off.strobe", 0, 0, 0, 1);

        // Recovery with C=3
        sq.delete();
        repeat (3) drive_period(3, 13);
        check("recover.stuck", int'(stuck), 0);
        check("recover.count", sq.size(), 2);
        check_strobe("recover.a", 0, 3, 16, 0);
        check_strobe("recover.b", 1, 3, 16, 0);

        // Stuck on while measuring
        sq.delete();
        pwm_in = 1'b0;
        tick(25);
        check("stuck_on.early", int'(stuck), 0);
        tick(15);
        check("stuck_on.stuck", int'(stuck), 1);
        check("stuck_on.count", sq.size(), 2);
        check_strobe("stuck_on.last", 0, 3, 16, 0);
        check_strobe("stuck_on.strobe", 1, 15, 0, 1);
        pwm_in = 1'b1;
        tick(5);

        // Reset in the middle of a low phase
        repeat (2) drive_period(5, 11);
        check("pre_rst.duty", int'(duty_out), 5);
        pwm_in = 1'b0;
        tick(2);
        rst = 1'b1;
        #1;
        check("mid_rst.duty", int'(duty_out), 0);
        check("mid_rst.period", int'(period_out), 0);
        check("mid_rst.valid", int'(valid), 0);
        check("mid_rst.stuck", int'(stuck), 0);
        tick(3);
        pwm_in = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(6);
        sq.delete();
        repeat (3) drive_period(5, 11);
        check("post_rst.count", sq.size(), 2);
        check_strobe("post_rst.a", 0, 5, 16, 0);
        check_strobe("post_rst.b", 1, 5, 16, 0);

        // Period change 16 -> 10
        sq.delete();
        repeat (4) drive_period(4, 6);
        check("per_chg.count", sq.size(), 4);
        check_strobe("per_chg.old", 0, 5, 16, 0);
        for (int i = 1; i < 4; i++)
            check_strobe($sformatf("per_chg.new%0d", i), i, 4, 10, 0);

        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
